// File: rtl/prio_dispatch_4_pkg.sv
// prio_pkg: shared widths and dispatch state encoding for prio_dispatch_4.
package prio_pkg;
    localparam int N_CH  = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;
endpackage

// File: rtl/prio_dispatch_4_grant_cnt.sv
// prio_grant_cnt: per-channel saturating grant counters with a combinational read mux.
module prio_grant_cnt
    import prio_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic [IDX_W-1:0] sel,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnts [N_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) cnts[i] <= '0;
        end else if (inc && cnts[inc_idx] != '1) begin
            cnts[inc_idx] <= cnts[inc_idx] + 1'b1;
        end
    end

    assign cnt = cnts[sel];
endmodule

// File: rtl/prio_dispatch_4.sv
// prio_dispatch_4: registered valid/ready dispatch of the encoder index with clear pulse and refractory gap.
// Optional grant counters are built when PRIO_DISPATCH_CNT_EN is defined.
module prio_dispatch_4
    import prio_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             req_vld,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_CH-1:0]  clr,
    output logic             busy,
    input  logic [IDX_W-1:0] cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("prio_dispatch_4: GAP must be within 1..15");
    end

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             acc;

    assign acc = state == ST_HOLD && out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            out_vld <= 1'b0;
            out_idx <= '0;
            clr     <= '0;
            busy    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            clr <= '0;
            case (state)
                ST_IDLE: if (req_vld) begin
                    out_idx <= req_idx;
                    out_vld <= 1'b1;
                    busy    <= 1'b1;
                    state   <= ST_HOLD;
                end
                ST_HOLD: if (acc) begin
                    out_vld <= 1'b0;
                    clr     <= N_CH'(1) << out_idx;
                    gap_cnt <= GAP_W'(GAP);
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt <= 1) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PRIO_DISPATCH_CNT_EN
    prio_grant_cnt u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (acc),
        .inc_idx (out_idx),
        .sel     (cnt_sel),
        .cnt     (cnt_out)
    );
`else
    logic unused_sel;
    assign unused_sel = ^cnt_sel;
    assign cnt_out    = '0;
`endif
endmodule

// File: tb/tb_prio_dispatch_4.sv
// tb_prio_dispatch_4: directed stimulus with an event-level reference model checked every cycle.
module tb_prio_dispatch_4;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_idx;
    logic       req_vld;
    logic       out_rdy;
    logic       out_vld;
    logic [1:0] out_idx;
    logic [3:0] clr;
    logic       busy;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_out;

    int tot = 0;
    int bad = 0;
    bit chk_on = 0;

    prio_dispatch_4 #(.GAP(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_idx (req_idx),
        .req_vld (req_vld),
        .out_rdy (out_rdy),
        .out_vld (out_vld),
        .out_idx (out_idx),
        .clr     (clr),
        .busy    (busy),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out)
    );

    always #5 clk = ~clk;

    // Reference: a pending dispatch, a cooldown length after each accept, and accept tallies.
    bit         m_vld;
    logic [1:0] m_idx;
    logic [3:0] m_clr;
    int         cool;
    int         m_cnt [4];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_vld = 0; m_idx = 0; m_clr = 0; cool = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            m_clr = 0;
            if (m_vld) begin
                if (out_rdy) begin
                    m_vld = 0;
                    m_clr = 4'b0001 << m_idx;
                    cool  = G;
                    if (m_cnt[m_idx] < 255) m_cnt[m_idx]++;
                end
            end else if (cool > 0) cool--;
            else if (req_vld) begin
                m_vld = 1;
                m_idx = req_idx;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input logic [1:0] s);
`ifdef PRIO_DISPATCH_CNT_EN
        return m_cnt[s];
`else
        return s == 2'd0 ? 0 : 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mdl_vld",  32'(out_vld), 32'(m_vld));
            chk("mdl_idx",  32'(out_idx), 32'(m_idx));
            chk("mdl_clr",  32'(clr),     32'(m_clr));
            chk("mdl_busy", 32'(busy),    32'(m_vld || cool > 0));
            chk("mdl_cnt",  32'(cnt_out), 32'(exp_cnt(cnt_sel)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int n;
        rst_n = 0; req_vld = 1; req_idx = 3; out_rdy = 0; cnt_sel = 0;
        repeat (3) tick();
        chk_on = 1;
        chk("rst_vld",  32'(out_vld), 0);
        chk("rst_clr",  32'(clr),     0);
        chk("rst_busy", 32'(busy),    0);
        chk("rst_cnt",  32'(cnt_out), 0);

        // single dispatch of index 2
        req_idx = 2; out_rdy = 1; rst_n = 1;
        tick();
        chk("one_vld",  32'(out_vld), 1);
        chk("one_idx",  32'(out_idx), 2);
        chk("one_busy", 32'(busy),    1);
        req_vld = 0;
        tick();
        chk("one_vld0",  32'(out_vld), 0);
        chk("one_clr",   32'(clr),     32'b0100);
        chk("one_busy1", 32'(busy),    1);
        tick();
        chk("one_clr0",  32'(clr),  0);
        chk("one_busy0", 32'(busy), 0);

        // backpressure while the encoder index moves
        out_rdy = 0; req_idx = 1; req_vld = 1;
        tick();
        chk("bp_idx", 32'(out_idx), 1);
        req_idx = 3;
        repeat (5) begin
            tick();
            chk("bp_hold_vld", 32'(out_vld), 1);
            chk("bp_hold_idx", 32'(out_idx), 1);
        end
        out_rdy = 1;
        tick();
        chk("bp_clr", 32'(clr),     32'b0010);
        chk("bp_vld", 32'(out_vld), 0);
        req_vld = 0;
        tick();
        chk("bp_clr0", 32'(clr), 0);

        // source holds request 0 until it sees its clear
        req_idx = 0; req_vld = 1; nd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_vld) nd++;
            if (clr != 0) req_vld = 0;
        end
        chk("dd_count", 32'(nd), 1);
        req_vld = 1;
        tick();
        chk("dd_again_vld", 32'(out_vld), 1);
        chk("dd_again_idx", 32'(out_idx), 0);
        req_vld = 0;
        repeat (3) tick();

        // reset while holding
        out_rdy = 0; req_vld = 1; req_idx = 3;
        tick();
        chk("mr_vld", 32'(out_vld), 1);
        rst_n = 0;
        tick();
        chk("mr_vld0",  32'(out_vld), 0);
        chk("mr_busy0", 32'(busy),    0);
        chk("mr_idx0",  32'(out_idx), 0);
        out_rdy = 1;
        tick();
        chk("mr_noclr", 32'(clr), 0);
        rst_n = 1; req_vld = 0;
        tick();
        chk("mr_noclr2", 32'(clr), 0);

        // 300 accepts on channel 3
        req_idx = 3; req_vld = 1; out_rdy = 1; n = 0;
        for (int i = 0; i < 1200 && n < 300; i++) begin
            tick();
            if (clr == 4'b1000) n++;
        end
        req_vld = 0;
        chk("sat_accepts", 32'(n), 300);
        repeat (3) tick();
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
`ifdef PRIO_DISPATCH_CNT_EN
            chk("sat_cnt", 32'(cnt_out), s == 3 ? 255 : 0);
`else
            chk("sat_cnt", 32'(cnt_out), 0);
`endif
        end
        tick();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
